// File: rtl/simon_key_sched_if.sv
// Request/response bundle between the cipher top level and the Simon-128/128
// key scheduler. The master side requests operations; the slave side is the scheduler.
interface simon_key_sched_if;
    logic         start_i;
    logic         key_load_i;
    logic         encrypt_i;
    logic [127:0] key_i;
    logic         round_en_o;
    logic [63:0]  kj_o;
    logic [6:0]   round_idx_o;
    logic         busy_o;
    logic         done_o;

    modport master (
        output start_i, key_load_i, encrypt_i, key_i,
        input  round_en_o, kj_o, round_idx_o, busy_o, done_o
    );

    modport slave (
        input  start_i, key_load_i, encrypt_i, key_i,
        output round_en_o, kj_o, round_idx_o, busy_o, done_o
    );
endinterface

// File: rtl/simon_key_sched.sv
// Simon-128/128 key schedule: expands the master key into 68 round keys, then
// replays them one per cycle (forward to encrypt, reverse to decrypt) into the round register.
module simon_key_sched (
    input  logic               clk,
    input  logic               rst,
    simon_key_sched_if.slave   bus
);
    localparam int         WORD     = 64;
    localparam int         ROUNDS   = 68;
    localparam logic [6:0] LAST_KEY = 7'(ROUNDS - 1);
    localparam logic [6:0] LAST_EXP = 7'(ROUNDS - 3);
    localparam logic [WORD-1:0] C_CONST = 64'hFFFF_FFFF_FFFF_FFFC;
    // z2 constant sequence, element 0 is the leftmost bit.
    localparam logic [0:61] Z2 = 62'b10101111011100000011010010011000101000010001111110010110110011;

    typedef enum logic [1:0] {IDLE, EXPAND, RUN, DONE} state_t;

    state_t          state_q, state_d;
    logic [WORD-1:0] mem [ROUNDS];
    logic [6:0]      i_q;
    logic [6:0]      ptr_q;
    logic            enc_q;
    logic            keys_valid_q;

    logic            accept;
    logic            need_expand;
    logic            run_last;
    logic [5:0]      z_idx;
    logic [WORD-1:0] k_prev, k_cur, t_rot, k_next;

    assign accept      = (state_q == IDLE) && bus.start_i;
    assign need_expand = bus.key_load_i || !keys_valid_q;
    assign run_last    = (ptr_q == (enc_q ? LAST_KEY : 7'd0));

    always_comb begin
        // NOTE: default assigned first so every path drives state_d; otherwise a latch is inferred.
        state_d = state_q;
        case (state_q)
            IDLE:    if (bus.start_i) state_d = need_expand ? EXPAND : RUN;
            EXPAND:  if (i_q == LAST_EXP) state_d = RUN;
            RUN:     if (run_last) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Next key from the two most recent ones; z index wraps after 62 entries.
    always_comb begin
        z_idx  = (i_q >= 7'd62) ? 6'(i_q - 7'd62) : i_q[5:0];
        k_prev = mem[i_q];
        k_cur  = mem[i_q + 7'd1];
        t_rot  = {k_cur[2:0], k_cur[WORD-1:3]};
        k_next = C_CONST ^ {63'd0, Z2[z_idx]} ^ k_prev ^ t_rot ^ {t_rot[0], t_rot[WORD-1:1]};
    end

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            i_q          <= '0;
            ptr_q        <= '0;
            enc_q        <= 1'b0;
            keys_valid_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE: if (bus.start_i) begin
                    enc_q <= bus.encrypt_i;
                    ptr_q <= bus.encrypt_i ? 7'd0 : LAST_KEY;
                    i_q   <= '0;
                    if (need_expand) keys_valid_q <= 1'b0;
                end
                EXPAND: begin
                    if (i_q == LAST_EXP) keys_valid_q <= 1'b1;
                    else                 i_q <= i_q + 7'd1;
                end
                RUN: if (!run_last) ptr_q <= enc_q ? ptr_q + 7'd1 : ptr_q - 7'd1;
                default: ;
            endcase
        end
    end

    // NOTE: key storage has no reset; its contents only matter once keys_valid_q is set.
    always_ff @(posedge clk) begin
        if (accept && need_expand) begin
            mem[0] <= bus.key_i[63:0];
            mem[1] <= bus.key_i[127:64];
        end else if (state_q == EXPAND) begin
            mem[i_q + 7'd2] <= k_next;
        end
    end

    assign bus.round_en_o  = (state_q == RUN);
    assign bus.kj_o        = (state_q == RUN) ? mem[ptr_q] : '0;
    assign bus.round_idx_o = (state_q == RUN) ? ptr_q : '0;
    assign bus.busy_o      = (state_q != IDLE);
    assign bus.done_o      = (state_q == DONE);
endmodule

// File: tb/tb_simon_key_sched.sv
// Directed bench for simon_key_sched: a behavioural Simon round register consumes
// the replayed keys and the result is compared against the published test vector.
module tb_simon_key_sched;
    localparam logic [127:0] KEY       = 128'h0f0e0d0c0b0a0908_0706050403020100;
    localparam logic [127:0] PT        = 128'h63736564207372656c6c657661727420;
    localparam logic [127:0] CT        = 128'h49681b1e1e54fe3f65aa832af84e0bbc;
    localparam logic [127:0] PT_SWAP   = 128'h6c6c657661727420_6373656420737265;
    localparam logic [127:0] OTHER_KEY = 128'hdeadbeef_cafef00d_01234567_89abcdef;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    simon_key_sched_if bus ();
    simon_key_sched dut (.clk(clk), .rst(rst), .bus(bus));

    int vectors     = 0;
    int miscompares = 0;

    logic [63:0]  ref_k [68];
    logic [127:0] text;
    logic         rnd_enc;
    logic [63:0]  rx, ry;

    function automatic logic [63:0] rol(input logic [63:0] x, input int n);
        return (x << n) | (x >> (64 - n));
    endfunction

    function automatic logic [63:0] ror(input logic [63:0] x, input int n);
        return (x >> n) | (x << (64 - n));
    endfunction

    // Round register: loads the text while idle, runs one forward round per enabled cycle.
    // Decryption loads swapped halves so the same forward round inverts the cipher.
    always @(posedge clk) begin
        if (!bus.round_en_o) begin
            if (rnd_enc) {rx, ry} <= text;
            else         {rx, ry} <= {text[63:0], text[127:64]};
        end else begin
            rx <= ry ^ ((rol(rx, 1) & rol(rx, 8)) ^ rol(rx, 2)) ^ bus.kj_o;
            ry <= rx;
        end
    end

    task automatic compute_ref(input logic [127:0] key);
        logic [61:0] z_seq;
        logic [63:0] t;
        z_seq    = 62'b10101111011100000011010010011000101000010001111110010110110011;
        ref_k[0] = key[63:0];
        ref_k[1] = key[127:64];
        for (int k = 2; k < 68; k++) begin
            t = ror(ref_k[k-1], 3);
            t = t ^ ror(t, 1);
            ref_k[k] = ~64'd3 ^ {63'd0, z_seq[61 - ((k - 2) % 62)]} ^ ref_k[k-2] ^ t;
        end
    endtask

    // Drives a start request in the current (low) clock phase; returns just after edge T.
    task automatic start_op(input logic kl, input logic enc, input logic [127:0] key);
        bus.start_i    = 1'b1;
        bus.key_load_i = kl;
        bus.encrypt_i  = enc;
        bus.key_i      = key;
        @(posedge clk);
        #1;
        bus.start_i    = 1'b0;
        bus.key_load_i = 1'b0;
        bus.encrypt_i  = ~enc;
        bus.key_i      = ~key;
    endtask

    // Observes cycles T+1 .. done; observation n is the cycle that ends at edge T+n.
    task automatic run_op(input logic expand, input logic enc, input logic [127:0] exp_ct,
                          input logic poke, input string name);
        int   first;
        int   done_at;
        int   act_en;
        int   act_done;
        int   idx;
        logic exp_en;
        first    = expand ? 67 : 1;
        done_at  = first + 68;
        act_en   = 0;
        act_done = 0;
        for (int n = 1; n <= done_at; n++) begin
            @(negedge clk);
            if (poke && (n == 30 || n == 100)) begin
                bus.start_i    = 1'b1;
                bus.key_load_i = 1'b1;
                bus.encrypt_i  = ~enc;
                bus.key_i      = OTHER_KEY;
            end else begin
                bus.start_i = 1'b0;
            end
            exp_en = (n >= first) && (n < done_at);
            if (bus.round_en_o === 1'b1) act_en++;
            if (bus.done_o === 1'b1) act_done++;
            vectors++;
            if (bus.round_en_o !== exp_en) begin
                miscompares++;
                $display("FAIL %s round_en n=%0d got %b want %b", name, n, bus.round_en_o, exp_en);
            end
            vectors++;
            if (bus.busy_o !== 1'b1) begin
                miscompares++;
                $display("FAIL %s busy n=%0d got %b want 1", name, n, bus.busy_o);
            end
            vectors++;
            if (bus.done_o !== (n == done_at)) begin
                miscompares++;
                $display("FAIL %s done n=%0d got %b want %b", name, n, bus.done_o, (n == done_at));
            end
            if (exp_en) begin
                idx = enc ? (n - first) : (67 - (n - first));
                vectors++;
                if (bus.round_idx_o !== 7'(idx)) begin
                    miscompares++;
                    $display("FAIL %s round_idx n=%0d got %0d want %0d", name, n, bus.round_idx_o, idx);
                end
                vectors++;
                if (bus.kj_o !== ref_k[idx]) begin
                    miscompares++;
                    $display("FAIL %s kj[%0d] got %h want %h", name, idx, bus.kj_o, ref_k[idx]);
                end
            end else begin
                vectors++;
                if (bus.round_idx_o !== 7'd0) begin
                    miscompares++;
                    $display("FAIL %s round_idx idle n=%0d got %0d want 0", name, n, bus.round_idx_o);
                end
            end
        end
        vectors++;
        if (act_en != 68) begin
            miscompares++;
            $display("FAIL %s round_en_count got %0d want 68", name, act_en);
        end
        vectors++;
        if (act_done != 1) begin
            miscompares++;
            $display("FAIL %s done_count got %0d want 1", name, act_done);
        end
        vectors++;
        if ({rx, ry} !== exp_ct) begin
            miscompares++;
            $display("FAIL %s ct got %h want %h", name, {rx, ry}, exp_ct);
        end
    endtask

    task automatic check_quiet(input string name);
        vectors++;
        if ({bus.round_en_o, bus.busy_o, bus.done_o} !== 3'b000) begin
            miscompares++;
            $display("FAIL %s en/busy/done got %b want 000", name,
                     {bus.round_en_o, bus.busy_o, bus.done_o});
        end
        vectors++;
        if ({bus.round_idx_o, bus.kj_o} !== 71'd0) begin
            miscompares++;
            $display("FAIL %s idx/kj got %0d/%h want 0/0", name, bus.round_idx_o, bus.kj_o);
        end
    endtask

    task automatic test_reset;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_quiet("reset_held");
        rst = 1'b0;
        @(negedge clk);
        check_quiet("reset_released");
    endtask

    task automatic test_encrypt_load;
        text    = PT;
        rnd_enc = 1'b1;
        compute_ref(KEY);
        @(negedge clk);
        start_op(1'b1, 1'b1, KEY);
        run_op(1'b1, 1'b1, CT, 1'b1, "encrypt_load");
    endtask

    task automatic test_back_to_back;
        @(negedge clk);
        vectors++;
        if (bus.busy_o !== 1'b0) begin
            miscompares++;
            $display("FAIL b2b_idle busy got %b want 0", bus.busy_o);
        end
        text    = CT;
        rnd_enc = 1'b0;
        start_op(1'b0, 1'b0, OTHER_KEY);
        run_op(1'b0, 1'b0, PT_SWAP, 1'b0, "decrypt_reuse");
    endtask

    task automatic test_mid_run_reset;
        text    = PT;
        rnd_enc = 1'b1;
        @(negedge clk);
        start_op(1'b0, 1'b1, OTHER_KEY);
        repeat (10) @(negedge clk);
        vectors++;
        if (bus.round_en_o !== 1'b1) begin
            miscompares++;
            $display("FAIL midrst_running round_en got %b want 1", bus.round_en_o);
        end
        rst = 1'b1;
        @(negedge clk);
        check_quiet("midrst_cycle1");
        @(negedge clk);
        check_quiet("midrst_cycle2");
        rst = 1'b0;
        @(negedge clk);
        check_quiet("midrst_released");
        // keys_valid was cleared, so a reuse request must expand key_i again.
        start_op(1'b0, 1'b1, KEY);
        run_op(1'b1, 1'b1, CT, 1'b0, "post_reset_expand");
    endtask

    initial begin
        rst            = 1'b1;
        bus.start_i    = 1'b0;
        bus.key_load_i = 1'b0;
        bus.encrypt_i  = 1'b0;
        bus.key_i      = '0;
        text           = '0;
        rnd_enc        = 1'b1;
        test_reset();
        test_encrypt_load();
        test_back_to_back();
        test_mid_run_reset();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
